// File: rtl/ioctl_pkg.sv
// Shared ioctl channel definitions: host command bytes and the upload FSM states.
// Also used by data_io for its own command decode.
package ioctl_pkg;

    localparam logic [7:0] UP_START = 8'h60;
    localparam logic [7:0] UP_DATA  = 8'h61;
    localparam logic [7:0] UP_END   = 8'h62;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        IDX,
        STREAM,
        IGNORE
    } up_state_e;

endpackage

// File: rtl/ioctl_upload_tx_if.sv
// Read port toward the SDRAM arbiter: one-cycle rd request, data returned with a valid strobe.
// The upload core is the master, the arbiter (or a memory model) is the slave.
interface ioctl_upload_tx_if #(
    parameter int ADDR_W = 25
) ();

    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic [7:0]        din;
    logic              din_valid;

    modport master (
        output addr,
        output rd,
        input  din,
        input  din_valid
    );

    modport slave (
        input  addr,
        input  rd,
        output din,
        output din_valid
    );

endinterface

// File: rtl/spi_pin_sync.sv
// Brings SPI_SCK/SPI_SS/SPI_DI into clk_sys through SYNC_FF flops (SYNC_FF >= 2)
// and derives single-cycle SCK rise/fall and SS fall pulses.
module spi_pin_sync #(
    parameter int SYNC_FF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sck,
    input  logic ss,
    input  logic di,
    output logic sck_s,
    output logic ss_s,
    output logic di_s,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_fall
);

    logic [SYNC_FF-1:0] sck_q, sck_d;
    logic [SYNC_FF-1:0] ss_q, ss_d;
    logic [SYNC_FF-1:0] di_q, di_d;
    logic               sck_prev_q, sck_prev_d;
    logic               ss_prev_q, ss_prev_d;

    always_comb begin
        sck_d      = {sck_q[SYNC_FF-2:0], sck};
        ss_d       = {ss_q[SYNC_FF-2:0], ss};
        di_d       = {di_q[SYNC_FF-2:0], di};
        sck_prev_d = sck_s;
        ss_prev_d  = ss_s;
    end

    // Idle levels on reset so no spurious edge is seen when it lifts.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_q      <= '0;
            ss_q       <= '1;
            di_q       <= '0;
            sck_prev_q <= 1'b0;
            ss_prev_q  <= 1'b1;
        end else begin
            sck_q      <= sck_d;
            ss_q       <= ss_d;
            di_q       <= di_d;
            sck_prev_q <= sck_prev_d;
            ss_prev_q  <= ss_prev_d;
        end
    end

    assign sck_s    = sck_q[SYNC_FF-1];
    assign ss_s     = ss_q[SYNC_FF-1];
    assign di_s     = di_q[SYNC_FF-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign ss_fall  = ~ss_s & ss_prev_q;

endmodule

// File: rtl/ioctl_upload_tx.sv
// SPI responder streaming core memory to the MCU on SS2, fed by a one-byte
// prefetch buffer that reads through the ioctl rd/valid port.
module ioctl_upload_tx
    import ioctl_pkg::*;
#(
    parameter int ADDR_W  = 25,
    parameter int SYNC_FF = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              SPI_SCK,
    input  logic              SPI_SS,
    input  logic              SPI_DI,
    output logic              SPI_DO,
    output logic              spi_do_oe,
    output logic              ioctl_upload,
    output logic [7:0]        ioctl_index,
    output logic              underrun,
    ioctl_upload_tx_if.master mem
);

    logic sck_s, ss_s, di_s, sck_rise, sck_fall, ss_fall;

    spi_pin_sync #(
        .SYNC_FF (SYNC_FF)
    ) u_sync (
        .clk      (clk_sys),
        .reset    (reset),
        .sck      (SPI_SCK),
        .ss       (SPI_SS),
        .di       (SPI_DI),
        .sck_s    (sck_s),
        .ss_s     (ss_s),
        .di_s     (di_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ss_fall  (ss_fall)
    );

    up_state_e         state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        rx_q, rx_d;
    logic [7:0]        tx_q, tx_d;
    logic [7:0]        buf_q, buf_d;
    logic              full_q, full_d;
    logic              pend_q, pend_d;
    logic              rd_q, rd_d;
    logic              skip_q, skip_d;
    logic              upload_q, upload_d;
    logic              underrun_q, underrun_d;
    logic [7:0]        index_q, index_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic       byte_done;
    logic [7:0] rx_byte;
    logic       is_start, is_data;
    logic       stream_entry, idx_done, cmd_end;
    logic       boundary, shift, load, consume, accept;

    assign byte_done = ~ss_s & sck_rise & (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_q, di_s};
    assign is_start  = rx_byte == UP_START;
    assign is_data   = (rx_byte == UP_DATA) & upload_q;

    always_ff @(posedge clk_sys) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (ss_fall) state_d = CMD;
            CMD: begin
                if (byte_done) begin
                    unique case (1'b1)
                        is_start: state_d = IDX;
                        is_data:  state_d = STREAM;
                        default:  state_d = IGNORE;
                    endcase
                end
            end
            IDX:     if (byte_done) state_d = IGNORE;
            default: state_d = state_q;
        endcase
        if (ss_s) state_d = IDLE;
    end

    // The fall right after entry is the command byte's own 8th fall: skip it.
    always_comb begin
        spi_do_oe    = state_q == STREAM;
        SPI_DO       = spi_do_oe ? tx_q[7] : 1'b1;
        stream_entry = (state_q == CMD) & byte_done & is_data;
        cmd_end      = (state_q == CMD) & byte_done & (rx_byte == UP_END);
        idx_done     = (state_q == IDX) & byte_done;
        boundary     = spi_do_oe & ~ss_s & sck_fall & ~skip_q
                       & (bit_cnt_q == 3'd0);
        shift        = spi_do_oe & ~ss_s & sck_fall & ~skip_q
                       & (bit_cnt_q != 3'd0);
        load         = stream_entry | boundary;
        consume      = load & full_q;
        accept       = mem.din_valid & pend_q;
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        buf_d      = buf_q;
        full_d     = full_q;
        pend_d     = pend_q;
        rd_d       = 1'b0;
        skip_d     = skip_q;
        upload_d   = upload_q;
        underrun_d = underrun_q;
        index_d    = index_q;
        addr_d     = addr_q;

        if (ss_s) begin
            bit_cnt_d = '0;
        end else if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            rx_d      = rx_byte[6:0];
        end

        if (load)       tx_d = full_q ? buf_q : 8'hFF;
        else if (shift) tx_d = {tx_q[6:0], 1'b1};

        if (stream_entry)              skip_d = 1'b1;
        else if (spi_do_oe & sck_fall) skip_d = 1'b0;

        // Old byte leaves before new data lands in the buffer.
        if (consume) full_d = 1'b0;
        if (accept) begin
            full_d = 1'b1;
            buf_d  = mem.din;
            pend_d = 1'b0;
        end
        if (consume) begin
            addr_d = addr_q + ADDR_W'(1);
            rd_d   = 1'b1;
            pend_d = 1'b1;
        end
        if (load & ~full_q) underrun_d = 1'b1;

        if (cmd_end) upload_d = 1'b0;
        if (idx_done) begin
            index_d    = rx_byte;
            addr_d     = '0;
            upload_d   = 1'b1;
            underrun_d = 1'b0;
            full_d     = 1'b0;
            rd_d       = 1'b1;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            tx_q       <= 8'hFF;
            buf_q      <= '0;
            full_q     <= 1'b0;
            pend_q     <= 1'b0;
            rd_q       <= 1'b0;
            skip_q     <= 1'b0;
            upload_q   <= 1'b0;
            underrun_q <= 1'b0;
            index_q    <= '0;
            addr_q     <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            buf_q      <= buf_d;
            full_q     <= full_d;
            pend_q     <= pend_d;
            rd_q       <= rd_d;
            skip_q     <= skip_d;
            upload_q   <= upload_d;
            underrun_q <= underrun_d;
            index_q    <= index_d;
            addr_q     <= addr_d;
        end
    end

    assign mem.addr     = addr_q;
    assign mem.rd       = rd_q;
    assign ioctl_upload = upload_q;
    assign ioctl_index  = index_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_ioctl_upload_tx.sv
// Bench for ioctl_upload_tx: SPI host driving SCK at clk/4, memory model
// answering addr^0xA5 after a programmable latency.
module tb_ioctl_upload_tx;
    import ioctl_pkg::*;

    localparam int ADDR_W = 25;
    localparam int HP     = 2;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       SPI_SCK, SPI_SS, SPI_DI;
    logic       SPI_DO, spi_do_oe, ioctl_upload, underrun;
    logic [7:0] ioctl_index;

    ioctl_upload_tx_if #(.ADDR_W(ADDR_W)) mem ();

    ioctl_upload_tx #(
        .ADDR_W  (ADDR_W),
        .SYNC_FF (2)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .SPI_SCK      (SPI_SCK),
        .SPI_SS       (SPI_SS),
        .SPI_DI       (SPI_DI),
        .SPI_DO       (SPI_DO),
        .spi_do_oe    (spi_do_oe),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .underrun     (underrun),
        .mem          (mem)
    );

    always #5 clk_sys = ~clk_sys;

    int                lat = 3;
    int                cnt = 0;
    int                rd_cnt = 0;
    int                oe_cnt = 0;
    logic [ADDR_W-1:0] last_rd_addr = '0;
    logic [ADDR_W-1:0] pend_addr = '0;

    always @(negedge clk_sys) begin
        mem.din_valid = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                mem.din_valid = 1'b1;
                mem.din       = pend_addr[7:0] ^ 8'hA5;
            end
        end
        if (mem.rd === 1'b1) begin
            rd_cnt++;
            last_rd_addr = mem.addr;
            pend_addr    = mem.addr;
            cnt          = lat;
        end
        if (spi_do_oe === 1'b1) oe_cnt++;
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic xbyte(input logic [7:0] tx, input int nbits,
                         input bit hold, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            SPI_DI = tx[i];
            tick(HP);
            SPI_SCK = 1'b1;
            tick(HP);
            rx[i] = SPI_DO;
            if (!(hold && i == 0)) SPI_SCK = 1'b0;
        end
    endtask

    task automatic sel();
        SPI_SS = 1'b0;
        tick(4);
    endtask

    task automatic desel();
        tick(4);
        SPI_SS = 1'b1;
        tick(4);
        SPI_SCK = 1'b0;
        tick(8);
    endtask

    task automatic cmd_frame(input logic [7:0] cmd, input bit has_arg,
                             input logic [7:0] arg);
        logic [7:0] d;
        sel();
        xbyte(cmd, 8, 1'b0, d);
        if (has_arg) xbyte(arg, 8, 1'b0, d);
        desel();
        tick(10);
    endtask

    typedef struct {
        logic [7:0] cmd;
        bit         has_arg;
        logic [7:0] arg;
        bit         exp_up;
        logic [7:0] exp_idx;
        int         exp_rds;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic [7:0] exp_str[4];
        logic [7:0] exp_und[4];
        int         rd0, oe0;

        vecs[0] = '{UP_START, 1'b1, 8'h05, 1'b1, 8'h05, 1};
        vecs[1] = '{8'h33,    1'b0, 8'h00, 1'b1, 8'h05, 0};
        vecs[2] = '{UP_END,   1'b0, 8'h00, 1'b0, 8'h05, 0};
        vecs[3] = '{UP_DATA,  1'b0, 8'h00, 1'b0, 8'h05, 0};
        vecs[4] = '{UP_START, 1'b1, 8'h05, 1'b1, 8'h05, 1};
        exp_str = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};
        exp_und = '{8'hA5, 8'hFF, 8'hA4, 8'hFF};

        SPI_SCK = 1'b0;
        SPI_SS  = 1'b1;
        SPI_DI  = 1'b0;
        reset   = 1'b1;
        tick(4);
        chk("rst SPI_DO", SPI_DO, 1);
        chk("rst oe", spi_do_oe, 0);
        chk("rst upload", ioctl_upload, 0);
        chk("rst index", ioctl_index, 0);
        chk("rst addr", mem.addr, 0);
        chk("rst rd", mem.rd, 0);
        chk("rst underrun", underrun, 0);
        reset = 1'b0;
        tick(4);

        for (int i = 0; i < 5; i++) begin
            rd0 = rd_cnt;
            oe0 = oe_cnt;
            cmd_frame(vecs[i].cmd, vecs[i].has_arg, vecs[i].arg);
            chk($sformatf("vec%0d upload", i), ioctl_upload, vecs[i].exp_up);
            chk($sformatf("vec%0d index", i), ioctl_index, vecs[i].exp_idx);
            chk($sformatf("vec%0d reads", i), rd_cnt - rd0, vecs[i].exp_rds);
            chk($sformatf("vec%0d oe", i), oe_cnt - oe0, 0);
            chk($sformatf("vec%0d addr", i), mem.addr, 0);
            chk($sformatf("vec%0d underrun", i), underrun, 0);
            if (vecs[i].exp_rds > 0)
                chk($sformatf("vec%0d rd addr", i), last_rd_addr, 0);
        end

        // Four-byte stream, SS lifted while SCK is still high after the last bit.
        rd0 = rd_cnt;
        sel();
        chk("stream oe before cmd", spi_do_oe, 0);
        xbyte(UP_DATA, 8, 1'b0, d);
        for (int i = 0; i < 4; i++) begin
            xbyte(8'h00, 8, i == 3, d);
            chk($sformatf("stream byte%0d", i), d, exp_str[i]);
            chk($sformatf("stream oe%0d", i), spi_do_oe, 1);
        end
        desel();
        chk("stream oe after", spi_do_oe, 0);
        chk("stream addr", mem.addr, 4);
        chk("stream reads", rd_cnt - rd0, 4);
        chk("stream underrun", underrun, 0);

        // Deselect after three bits, then resume.
        sel();
        xbyte(UP_DATA, 8, 1'b0, d);
        xbyte(8'h00, 3, 1'b0, d);
        chk("partial bits", d[7:5], 3'b101);
        desel();
        sel();
        xbyte(UP_DATA, 8, 1'b0, d);
        xbyte(8'h00, 8, 1'b1, d);
        chk("resume byte", d, 8'hA0);
        desel();
        chk("resume addr", mem.addr, 6);
        chk("resume rd addr", last_rd_addr, 6);

        // Slow memory: every other byte misses its boundary.
        lat = 40;
        cmd_frame(UP_START, 1'b1, 8'h07);
        tick(100);
        chk("und start index", ioctl_index, 8'h07);
        chk("und start flag", underrun, 0);
        sel();
        xbyte(UP_DATA, 8, 1'b0, d);
        for (int i = 0; i < 4; i++) begin
            xbyte(8'h00, 8, i == 3, d);
            chk($sformatf("und byte%0d", i), d, exp_und[i]);
        end
        desel();
        chk("und sticky", underrun, 1);
        tick(60);
        chk("und still sticky", underrun, 1);
        lat = 3;
        cmd_frame(UP_START, 1'b1, 8'h02);
        chk("und cleared", underrun, 0);
        chk("und new index", ioctl_index, 8'h02);

        // Reset in the middle of a byte with a read in flight.
        lat = 20;
        sel();
        xbyte(UP_DATA, 8, 1'b0, d);
        xbyte(8'h00, 2, 1'b0, d);
        reset  = 1'b1;
        SPI_SS = 1'b1;
        tick(1);
        chk("mid rst SPI_DO", SPI_DO, 1);
        chk("mid rst oe", spi_do_oe, 0);
        chk("mid rst upload", ioctl_upload, 0);
        chk("mid rst index", ioctl_index, 0);
        chk("mid rst addr", mem.addr, 0);
        chk("mid rst rd", mem.rd, 0);
        chk("mid rst underrun", underrun, 0);
        tick(1);
        reset = 1'b0;
        tick(40);
        chk("post rst upload", ioctl_upload, 0);
        lat = 3;
        rd0 = rd_cnt;
        cmd_frame(UP_START, 1'b1, 8'h0B);
        chk("fresh upload", ioctl_upload, 1);
        chk("fresh index", ioctl_index, 8'h0B);
        chk("fresh reads", rd_cnt - rd0, 1);
        chk("fresh rd addr", last_rd_addr, 0);
        sel();
        xbyte(UP_DATA, 8, 1'b0, d);
        xbyte(8'h00, 8, 1'b1, d);
        chk("fresh byte", d, 8'hA5);
        desel();
        chk("fresh addr", mem.addr, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
